// File: rtl/alu_iterative_if.sv
// Request/response bundle between the decoder stage and the iterative ALU.
// The master issues operations and the slave returns registered results.
interface alu_iterative_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [2:0]         select_bits_ALU;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;

    modport master (
        output start, select_bits_ALU, a, b, shamt,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, select_bits_ALU, a, b, shamt,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU. Logic/arithmetic ops finish in one cycle; SRL shifts
// one bit per cycle so no barrel shifter is required.
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_iterative_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SLT = 3'b011,
        OP_SUB = 3'b100,
        OP_SRL = 3'b101,
        OP_XOR = 3'b110,
        OP_NOR = 3'b111
    } op_e;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e             state, state_next;
    logic [WIDTH-1:0]   shreg, shreg_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0]   result_q, result_next;
    logic               zero_q, ovf_q, ovf_next, done_q, load;
    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf;
    op_e                op;

    assign op   = op_e'(bus.select_bits_ALU);
    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    // Single-cycle datapath; SRL yields b unchanged, which is the shamt=0 result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SRL: alu_res = bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOR: alu_res = ~(bus.a | bus.b);
            default: alu_res = '0;
        endcase
    end

    // Next-state logic: accept requests in IDLE, step the shifter in SHIFT.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        result_next = result_q;
        ovf_next    = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (op == OP_SRL && bus.shamt != '0) begin
                        shreg_next = bus.b;
                        cnt_next   = bus.shamt;
                        state_next = SHIFT;
                    end else begin
                        load        = 1'b1;
                        result_next = alu_res;
                        ovf_next    = alu_ovf;
                    end
                end
            end
            SHIFT: begin
                shreg_next = shreg >> 1;
                cnt_next   = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    load        = 1'b1;
                    result_next = shreg >> 1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, shifter and result registers; flags move only on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state  <= state_next;
            shreg  <= shreg_next;
            cnt    <= cnt_next;
            done_q <= load;
            if (load) begin
                result_q <= result_next;
                zero_q   <= (result_next == '0);
                ovf_q    <= ovf_next;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_alu_iterative;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] held;

    always #5 clk = ~clk;

    alu_iterative_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    alu_iterative #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; everything after this sits mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model from the operation definitions, using wide signed math.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic ov);
        longint sa, sb, s;
        logic signed [31:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        ov = 1'b0;
        r  = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = s[31:0]; t = s[31:0]; ov = (longint'(t) != s); end
            3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: begin s = sa - sb; r = s[31:0]; t = s[31:0]; ov = (longint'(t) != s); end
            3'd5: r = b >> sh;
            3'd6: r = a ^ b;
            default: r = ~(a | b);
        endcase
    endtask

    // Issue one op in the current cycle and check every cycle up to done.
    // Ends in the done cycle so the next call issues back-to-back.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input string tag);
        logic [31:0] er;
        logic        eo;
        int          lat;
        model(op, a, b, sh, er, eo);
        lat = (op == 3'd5 && sh != 0) ? int'(sh) + 1 : 1;
        bus.start = 1'b1;
        bus.select_bits_ALU = op;
        bus.a = a;
        bus.b = b;
        bus.shamt = sh;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < lat; c++) begin
            check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            check({tag, " early_done"}, {31'd0, bus.done}, 32'd0);
            check({tag, " held_result"}, bus.result, held);
            bus.a = $urandom;
            bus.b = $urandom;
            bus.shamt = SHAMT_W'($urandom);
            bus.select_bits_ALU = 3'($urandom);
            step();
        end
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " busy_end"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " result"}, bus.result, er);
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
        held = er;
    endtask

    initial begin
        logic [31:0] er;
        logic        eo;
        logic [2:0]  ops [4];
        logic [31:0] corner [5];
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic [4:0]  rsh;

        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
        held = 32'd0;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.select_bits_ALU = 3'd0;
        bus.a = '0;
        bus.b = '0;
        bus.shamt = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst result", bus.result, 32'd0);
        check("rst zero", {31'd0, bus.zero}, 32'd1);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst overflow", {31'd0, bus.overflow}, 32'd0);

        // Arithmetic corners.
        run_op(3'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, "add_ovf");
        check("add_ovf const", bus.result, 32'h8000_0000);
        check("add_ovf flag", {31'd0, bus.overflow}, 32'd1);
        step();
        check("add single pulse", {31'd0, bus.done}, 32'd0);
        run_op(3'd4, 32'd5, 32'd5, 5'd0, "sub_zero");
        check("sub_zero const", {31'd0, bus.zero}, 32'd1);
        run_op(3'd3, 32'h8000_0000, 32'd1, 5'd0, "slt_neg");
        check("slt_neg const", bus.result, 32'd1);
        run_op(3'd3, 32'd1, 32'h8000_0000, 5'd0, "slt_pos");
        check("slt_pos const", bus.result, 32'd0);

        // Shifts, including shamt=0 and back-to-back SRLs.
        run_op(3'd5, 32'h1234_5678, 32'hF000_0000, 5'd4, "srl4");
        check("srl4 const", bus.result, 32'h0F00_0000);
        run_op(3'd5, 32'd0, 32'h0000_ABCD, 5'd0, "srl0");
        check("srl0 const", bus.result, 32'h0000_ABCD);
        run_op(3'd5, 32'd0, 32'hDEAD_BEEF, 5'd3, "srl_b2b_a");
        run_op(3'd5, 32'd0, 32'h8000_0001, 5'd1, "srl_b2b_b");
        step();
        check("srl single pulse", {31'd0, bus.done}, 32'd0);

        // SRL by 31 with start/AND held during the shift: must be ignored.
        bus.start = 1'b1;
        bus.select_bits_ALU = 3'd5;
        bus.b = 32'h8000_1234;
        bus.shamt = 5'd31;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            if (c >= 2 && c <= 10) begin
                bus.start = 1'b1;
                bus.select_bits_ALU = 3'd0;
                bus.a = 32'hFFFF_FFFF;
                bus.b = 32'hFFFF_FFFF;
            end else begin
                bus.start = 1'b0;
            end
            check("srl31 no_done", {31'd0, bus.done}, 32'd0);
            check("srl31 busy", {31'd0, bus.busy}, 32'd1);
            step();
        end
        bus.start = 1'b0;
        check("srl31 done", {31'd0, bus.done}, 32'd1);
        check("srl31 result", bus.result, 32'd1);
        step();
        check("srl31 no_queued", {31'd0, bus.done}, 32'd0);
        check("srl31 held", bus.result, 32'd1);
        held = 32'd1;

        // Reset in cycle 3 of an 8-bit shift.
        bus.start = 1'b1;
        bus.select_bits_ALU = 3'd5;
        bus.b = 32'hFFFF_0000;
        bus.shamt = 5'd8;
        step();
        bus.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_mid result", bus.result, 32'd0);
        check("rst_mid busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid zero", {31'd0, bus.zero}, 32'd1);
        step();
        check("rst_mid done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        held = 32'd0;
        // Issued in the first cycle after reset release.
        run_op(3'd1, 32'h0000_00F0, 32'h0000_000F, 5'd0, "post_rst");

        // Four logic ops back-to-back.
        ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd6; ops[3] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'b1;
            bus.select_bits_ALU = ops[i];
            bus.a = 32'hFF00_FF00;
            bus.b = 32'h0F0F_0F0F;
            step();
            model(ops[i], 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, er, eo);
            check($sformatf("b2b%0d done", i), {31'd0, bus.done}, 32'd1);
            check($sformatf("b2b%0d result", i), bus.result, er);
        end
        check("b2b nor const", bus.result, 32'h00F0_00F0);
        bus.start = 1'b0;
        step();
        check("b2b end", {31'd0, bus.done}, 32'd0);
        held = 32'h00F0_00F0;

        // Random operations, issued back-to-back with corner operands mixed in.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rsh = 5'($urandom_range(0, 31));
            run_op(rop, ra, rb, rsh, $sformatf("rnd%0d", i));
        end
        bus.start = 1'b0;
        step();
        check("final idle", {31'd0, bus.done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
